// File: rtl/reg_wb_sequencer.sv
// Register write-back sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK. It drives the
// destination select and write strobe of decoder_3to8. Define SEQ_R0_PROTECT_EN to suppress writes to register 0.
module reg_wb_sequencer #(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned DEST_LSB    = 8,
  parameter int unsigned WB_BIT      = 15,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  output logic [2:0]         wb_sel,
  output logic               wb_enable,
  output logic [1:0]         phase,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] dest_q;
  logic       wbf_q;
  logic       ready_q;
  logic [2:0] wb_sel_q;
  logic       wb_en_q;
  logic       done_q;
  logic       wb_fire_d;

  // Only the destination field and the WB flag are consumed; the rest of the word is opcode
  // content for later pipeline stages.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr;

`ifdef SEQ_R0_PROTECT_EN
  assign wb_fire_d = wbf_q && (dest_q != '0);
`else
  assign wb_fire_d = wbf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dest_q   <= '0;
      wbf_q    <= 1'b0;
      ready_q  <= 1'b1;
      wb_sel_q <= '0;
      wb_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid && ready_q) begin
            dest_q  <= instr[DEST_LSB +: 3];
            wbf_q   <= instr[WB_BIT];
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          wb_sel_q <= dest_q;
          cnt_q    <= EXEC_LOAD;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          // Strobe and done are registered on the way into WRITEBACK so they coincide with phase 3.
          if (!stall) begin
            if (cnt_q == 4'd0) begin
              wb_en_q <= wb_fire_d;
              done_q  <= 1'b1;
              state_q <= S_WB;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        S_WB: begin
          wb_en_q <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign wb_sel      = wb_sel_q;
  assign wb_enable   = wb_en_q;
  assign done        = done_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Scoreboard bench for reg_wb_sequencer. The driver queues each expected write-back.
// The monitor pops an entry and checks it on every done pulse.
module tb_reg_wb_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        stall;
  logic [2:0]  wb_sel;
  logic        wb_enable;
  logic [1:0]  phase;
  logic        done;

  typedef struct {
    logic [2:0] sel;
    logic       en;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_acc = 0;

`ifdef SEQ_R0_PROTECT_EN
  localparam logic R0_EN = 1'b0;
`else
  localparam logic R0_EN = 1'b1;
`endif

  reg_wb_sequencer #(
    .INSTR_W    (16),
    .DEST_LSB   (8),
    .WB_BIT     (15),
    .EXEC_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .stall      (stall),
    .wb_sel     (wb_sel),
    .wb_enable  (wb_enable),
    .phase      (phase),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Call this task at a negedge. It returns at the negedge after the accepting edge and leaves
  // instr_valid high.
  task automatic send(input logic [15:0] w, input int stalls, input logic exp_en, input bit push);
    int n;
    instr       = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, instr_ready}, 32'd1);
    last_acc = cyc + 1;
    if (push) sb.push_back('{w[10:8], exp_en, last_acc + 3 + stalls});
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, instr_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) chk("strobe_outside_wb", {31'd0, ((wb_enable | done) && phase != 2'd3)}, 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_sel", {29'd0, wb_sel}, {29'd0, e.sel});
        chk("wb_enable", {31'd0, wb_enable}, {31'd0, e.en});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int t1;
    int n;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    stall       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_phase", {30'd0, phase}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_en", {31'd0, wb_enable}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wb_sel", {29'd0, wb_sel}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain write to r3: phases 1,2,2,3
    send(16'h8300, 0, 1'b1, 1'b1);
    instr_valid = 1'b0;
    chk("t2_ph1", {30'd0, phase}, 32'd1);
    @(negedge clk);
    chk("t2_ph2a", {30'd0, phase}, 32'd2);
    @(negedge clk);
    chk("t2_ph2b", {30'd0, phase}, 32'd2);
    @(negedge clk);
    chk("t2_ph3", {30'd0, phase}, 32'd3);
    wait_idle();

    // No write flag: done without strobe
    send(16'h0500, 0, 1'b0, 1'b1);
    instr_valid = 1'b0;
    wait_idle();

    // Three stalled cycles in EXECUTE
    send(16'h8700, 3, 1'b1, 1'b1);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("t4_in_exec", {30'd0, phase}, 32'd2);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    wait_idle();

    // Back-to-back with valid held high
    send(16'h8100, 0, 1'b1, 1'b1);
    t1 = last_acc;
    send(16'h8600, 0, 1'b1, 1'b1);
    instr_valid = 1'b0;
    chk("t5_spacing", last_acc - t1, 32'd5);
    wait_idle();

    // Destination r0
    send(16'h8000, 0, R0_EN, 1'b1);
    instr_valid = 1'b0;
    wait_idle();

    // Reset mid-EXECUTE: the in-flight instruction is dropped
    send(16'h8300, 0, 1'b1, 1'b0);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("t1_in_exec", {30'd0, phase}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_phase", {30'd0, phase}, 32'd0);
    chk("t1_rst_wb_en", {31'd0, wb_enable}, 32'd0);
    chk("t1_rst_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t1_stays_idle", {30'd0, phase}, 32'd0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
